// File: rtl/true_dual_port_ram.sv
// True dual-port RAM, single clock. Registered read on each port with a
// per-port write mode and an optional extra output register per port.
// The array has no reset so it maps onto block RAM; only the read/output
// registers are cleared by rstn.
module true_dual_port_ram #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter string       WRITE_MODE_1 = "READ_FIRST",
  parameter string       WRITE_MODE_2 = "READ_FIRST",
  parameter string       OUTPUT_REG_1 = "FALSE",
  parameter string       OUTPUT_REG_2 = "FALSE"
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  we1,
  input  logic [DATA_WIDTH-1:0] din1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  input  logic                  we2,
  input  logic [DATA_WIDTH-1:0] din2,
  input  logic [ADDR_WIDTH-1:0] addr2,
  output logic [DATA_WIDTH-1:0] dout2
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  localparam int unsigned ModeReadFirst  = 0;
  localparam int unsigned ModeWriteFirst = 1;
  localparam int unsigned ModeNoChange   = 2;
  localparam int unsigned ModeIllegal    = 3;

  localparam int unsigned Mode1 =
    (WRITE_MODE_1 == "READ_FIRST")  ? ModeReadFirst  :
    (WRITE_MODE_1 == "WRITE_FIRST") ? ModeWriteFirst :
    (WRITE_MODE_1 == "NO_CHANGE")   ? ModeNoChange   : ModeIllegal;
  localparam int unsigned Mode2 =
    (WRITE_MODE_2 == "READ_FIRST")  ? ModeReadFirst  :
    (WRITE_MODE_2 == "WRITE_FIRST") ? ModeWriteFirst :
    (WRITE_MODE_2 == "NO_CHANGE")   ? ModeNoChange   : ModeIllegal;

  localparam bit OutReg1 = (OUTPUT_REG_1 == "TRUE");
  localparam bit OutReg2 = (OUTPUT_REG_2 == "TRUE");
  localparam bit OutRegOk1 = OutReg1 || (OUTPUT_REG_1 == "FALSE");
  localparam bit OutRegOk2 = OutReg2 || (OUTPUT_REG_2 == "FALSE");

  // Reject unsupported parameter strings at elaboration.
  if (Mode1 == ModeIllegal) begin : g_bad_mode1
    $error("true_dual_port_ram: illegal WRITE_MODE_1 '%s'", WRITE_MODE_1);
  end
  if (Mode2 == ModeIllegal) begin : g_bad_mode2
    $error("true_dual_port_ram: illegal WRITE_MODE_2 '%s'", WRITE_MODE_2);
  end
  if (!OutRegOk1) begin : g_bad_oreg1
    $error("true_dual_port_ram: illegal OUTPUT_REG_1 '%s'", OUTPUT_REG_1);
  end
  if (!OutRegOk2) begin : g_bad_oreg2
    $error("true_dual_port_ram: illegal OUTPUT_REG_2 '%s'", OUTPUT_REG_2);
  end

  // Power-up contents are zero; rstn never touches the array.
  logic [DATA_WIDTH-1:0] mem [Depth] = '{default: '0};

  logic [DATA_WIDTH-1:0] rd1_q;
  logic [DATA_WIDTH-1:0] rd2_q;

  // Array writes; port 2 is issued last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (rstn) begin
      if (we1) mem[addr1] <= din1;
      if (we2) mem[addr2] <= din2;
    end
  end

  // Port-1 read register; mem reads return pre-edge contents (old data).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd1_q <= '0;
    end else if (we1 && (Mode1 == ModeWriteFirst)) begin
      rd1_q <= din1;
    end else if (we1 && (Mode1 == ModeNoChange)) begin
      rd1_q <= rd1_q;
    end else begin
      rd1_q <= mem[addr1];
    end
  end

  // Port-2 read register; same scheme as port 1.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd2_q <= '0;
    end else if (we2 && (Mode2 == ModeWriteFirst)) begin
      rd2_q <= din2;
    end else if (we2 && (Mode2 == ModeNoChange)) begin
      rd2_q <= rd2_q;
    end else begin
      rd2_q <= mem[addr2];
    end
  end

  if (OutReg1) begin : g_oreg1
    logic [DATA_WIDTH-1:0] out1_q;
    // Free-running output stage: adds one cycle of read latency.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) out1_q <= '0;
      else       out1_q <= rd1_q;
    end
    assign dout1 = out1_q;
  end else begin : g_noreg1
    assign dout1 = rd1_q;
  end

  if (OutReg2) begin : g_oreg2
    logic [DATA_WIDTH-1:0] out2_q;
    // Free-running output stage: adds one cycle of read latency.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) out2_q <= '0;
      else       out2_q <= rd2_q;
    end
    assign dout2 = out2_q;
  end else begin : g_noreg2
    assign dout2 = rd2_q;
  end

endmodule

// File: tb/tb_true_dual_port_ram.sv
// Bench for true_dual_port_ram. Two instances share every input:
//   u_a: port 1 WRITE_FIRST, port 2 NO_CHANGE, no output registers.
//   u_b: both ports READ_FIRST, port 1 with the extra output register.
// Expected values are queued per output with the cycle they fall due; a
// monitor on the falling edge pops and compares them.
module tb_true_dual_port_ram;

  logic       clk = 1'b0;
  logic       rstn;
  logic       we1, we2;
  logic [7:0] din1, din2, addr1, addr2;
  logic [7:0] a_dout1, a_dout2, b_dout1, b_dout2;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    int         due;
    logic [7:0] val;
    string      name;
  } exp_t;

  exp_t q_a1[$];
  exp_t q_a2[$];
  exp_t q_b1[$];
  exp_t q_b2[$];

  true_dual_port_ram #(
    .DATA_WIDTH  (8),
    .ADDR_WIDTH  (8),
    .WRITE_MODE_1("WRITE_FIRST"),
    .WRITE_MODE_2("NO_CHANGE"),
    .OUTPUT_REG_1("FALSE"),
    .OUTPUT_REG_2("FALSE")
  ) u_a (
    .clk  (clk),
    .rstn (rstn),
    .we1  (we1),
    .din1 (din1),
    .addr1(addr1),
    .dout1(a_dout1),
    .we2  (we2),
    .din2 (din2),
    .addr2(addr2),
    .dout2(a_dout2)
  );

  true_dual_port_ram #(
    .DATA_WIDTH  (8),
    .ADDR_WIDTH  (8),
    .WRITE_MODE_1("READ_FIRST"),
    .WRITE_MODE_2("READ_FIRST"),
    .OUTPUT_REG_1("TRUE"),
    .OUTPUT_REG_2("FALSE")
  ) u_b (
    .clk  (clk),
    .rstn (rstn),
    .we1  (we1),
    .din1 (din1),
    .addr1(addr1),
    .dout1(b_dout1),
    .we2  (we2),
    .din2 (din2),
    .addr2(addr2),
    .dout2(b_dout2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string ch, input exp_t e, input logic [7:0] act);
    n_checks++;
    if (e.due == cyc && act === e.val) begin
      n_pass++;
    end else begin
      $display("FAIL %s %s at cycle %0d (due %0d): got %h, expected %h",
               ch, e.name, cyc, e.due, act, e.val);
    end
  endtask

  // Monitor: compare every expectation that has fallen due.
  always @(negedge clk) begin
    while (q_a1.size() > 0 && q_a1[0].due <= cyc) check("a.dout1", q_a1.pop_front(), a_dout1);
    while (q_a2.size() > 0 && q_a2[0].due <= cyc) check("a.dout2", q_a2.pop_front(), a_dout2);
    while (q_b1.size() > 0 && q_b1[0].due <= cyc) check("b.dout1", q_b1.pop_front(), b_dout1);
    while (q_b2.size() > 0 && q_b2[0].due <= cyc) check("b.dout2", q_b2.pop_front(), b_dout2);
  end

  task automatic push(input int ch, input int off, input logic [7:0] v, input string nm);
    exp_t e;
    e.due  = cyc + off;
    e.val  = v;
    e.name = nm;
    case (ch)
      0:       q_a1.push_back(e);
      1:       q_a2.push_back(e);
      2:       q_b1.push_back(e);
      default: q_b2.push_back(e);
    endcase
  endtask

  // Drive one cycle of inputs, queue the four expected outputs, advance.
  task automatic step(input string nm,
                      input logic w1, input logic [7:0] d1, input logic [7:0] ad1,
                      input logic w2, input logic [7:0] d2, input logic [7:0] ad2,
                      input logic [7:0] ea1, input logic [7:0] ea2,
                      input logic [7:0] eb1, input logic [7:0] eb2);
    we1 = w1; din1 = d1; addr1 = ad1;
    we2 = w2; din2 = d2; addr2 = ad2;
    push(0, 1, ea1, nm);
    push(1, 1, ea2, nm);
    push(2, 2, eb1, nm);
    push(3, 1, eb2, nm);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held with a write pending on port 2 to address 0.
    rstn = 1'b0;
    we1 = 1'b0; din1 = 8'h00; addr1 = 8'h00;
    we2 = 1'b1; din2 = 8'hFF; addr2 = 8'h00;
    for (int r = 0; r < 2; r++) begin
      push(0, 1, 8'h00, "reset");
      push(1, 1, 8'h00, "reset");
      push(2, 1, 8'h00, "reset");
      push(3, 1, 8'h00, "reset");
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    #1;
    rstn = 1'b1;

    //    name          we1  din1   addr1  we2  din2   addr2  a1     a2     b1     b2
    step("rd0_post_rst", 0, 8'h00, 8'd0,  0, 8'h00, 8'd0,  8'h00, 8'h00, 8'h00, 8'h00);
    step("wr_a5",        0, 8'h00, 8'd0,  1, 8'hA5, 8'd3,  8'h00, 8'h00, 8'h00, 8'h00);
    step("wr_5a_rd3",    0, 8'h00, 8'd3,  1, 8'h5A, 8'd4,  8'hA5, 8'h00, 8'hA5, 8'h00);
    step("rd4",          0, 8'h00, 8'd4,  0, 8'h00, 8'd4,  8'h5A, 8'h5A, 8'h5A, 8'h5A);
    step("p1_pre_11",    1, 8'h11, 8'd7,  0, 8'h00, 8'd3,  8'h11, 8'hA5, 8'h00, 8'hA5);
    step("p1_wr_22",     1, 8'h22, 8'd7,  0, 8'h00, 8'd7,  8'h22, 8'h11, 8'h11, 8'h11);
    step("rd7_p2_wr33",  0, 8'h00, 8'd7,  1, 8'h33, 8'd4,  8'h22, 8'h11, 8'h22, 8'h5A);
    step("p2_pre_3c",    0, 8'h00, 8'd4,  1, 8'h3C, 8'd8,  8'h33, 8'h11, 8'h33, 8'h00);
    step("p2_wr_c3",     0, 8'h00, 8'd8,  1, 8'hC3, 8'd8,  8'h3C, 8'h11, 8'h3C, 8'h3C);
    step("rd8",          0, 8'h00, 8'd8,  0, 8'h00, 8'd8,  8'hC3, 8'hC3, 8'hC3, 8'hC3);
    step("p1_pre_01",    1, 8'h01, 8'd9,  0, 8'h00, 8'd8,  8'h01, 8'hC3, 8'h00, 8'hC3);
    step("xport_rdw",    0, 8'h00, 8'd9,  1, 8'h02, 8'd9,  8'h01, 8'hC3, 8'h01, 8'h01);
    step("rd9_new",      0, 8'h00, 8'd9,  0, 8'h00, 8'd9,  8'h02, 8'h02, 8'h02, 8'h02);
    step("collide",      1, 8'h33, 8'd9,  1, 8'h44, 8'd9,  8'h33, 8'h02, 8'h02, 8'h02);
    step("rd9_p2_wins",  0, 8'h00, 8'd9,  0, 8'h00, 8'd9,  8'h44, 8'h44, 8'h44, 8'h44);
    step("wr77",         0, 8'h00, 8'd9,  1, 8'h77, 8'd1,  8'h44, 8'h44, 8'h44, 8'h00);
    // Output register: after the edge sampling addr1=1, b.dout1 still shows the prior read.
    push(2, 1, 8'h44, "oreg_not_early");
    step("oreg_rd1",     0, 8'h00, 8'd1,  0, 8'h00, 8'd9,  8'h77, 8'h44, 8'h77, 8'h44);

    // Preload addresses 0..15 with addr*3 through port 2.
    for (int i = 0; i < 16; i++) begin
      we1 = 1'b0; din1 = 8'h00; addr1 = 8'd0;
      we2 = 1'b1; din2 = 8'(i * 3); addr2 = 8'(i);
      @(posedge clk);
      #1;
    end

    // Back-to-back reads: port 1 ascending, port 2 descending.
    for (int i = 0; i < 16; i++) begin
      step("stream", 0, 8'h00, 8'(i), 0, 8'h00, 8'(15 - i),
           8'(i * 3), 8'((15 - i) * 3), 8'(i * 3), 8'((15 - i) * 3));
    end

    we1 = 1'b0; we2 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;

    n_checks++;
    if (q_a1.size() + q_a2.size() + q_b1.size() + q_b2.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL drain: got %0d unchecked expectations, expected 0",
               q_a1.size() + q_a2.size() + q_b1.size() + q_b2.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
